// File: rtl/pipelined_block_adder_if.sv
// Operand/result bundle for pipelined_block_adder.
//   in_valid / in_ready   : operand handshake (producer -> adder)
//   a, b, cy_in, sub      : operands, carry in (ignored for sub), op select
//   out_valid / out_ready : result handshake (adder -> consumer)
//   sum, cy_out, ovf      : result, carry out of MSB, signed overflow
// master = producer/consumer side, slave = the adder.
interface pipelined_block_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cy_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cy_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, cy_in, sub, out_ready,
    input  in_ready, out_valid, sum, cy_out, ovf
  );

  modport slave (
    input  in_valid, a, b, cy_in, sub, out_ready,
    output in_ready, out_valid, sum, cy_out, ovf
  );
endinterface

// File: rtl/pipelined_block_adder.sv
// Pipelined block carry-lookahead adder/subtractor.
// A WIDTH-bit operation is split into WIDTH/BLOCK lookahead blocks; block k
// is resolved in stage k+1 and its carry is registered into the next stage.
// One operation per cycle; the whole pipe freezes while the output is
// presented and not taken.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears control and datapath)
//   bus   : slave side of pipelined_block_adder_if (see interface header)
module pipelined_block_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipelined_block_adder_if.slave  bus
);

  localparam int NB = (BLOCK < 1) ? 1 : WIDTH / BLOCK;

  if (BLOCK < 1) begin : g_bad_block
    $error("pipelined_block_adder: BLOCK must be at least 1");
  end else if ((WIDTH % BLOCK) != 0) begin : g_bad_width
    $error("pipelined_block_adder: WIDTH must be a multiple of BLOCK");
  end

  // Lookahead block: every internal carry is a flat sum of generate terms
  // gated by the propagates above them, so no carry waits on its neighbour.
  // Returns {carry into top bit, carry out, sum bits}.
  function automatic logic [BLOCK+1:0] cla_block(
    input logic [BLOCK-1:0] x,
    input logic [BLOCK-1:0] y,
    input logic             cin
  );
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             t;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      t = cin;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return {c[BLOCK-1], c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  // Stage registers, index k holds the state after block k is resolved.
  logic [WIDTH-1:0] a_p   [NB];
  logic [WIDTH-1:0] b_p   [NB];
  logic [WIDTH-1:0] sum_p [NB];
  logic             cy_p  [NB];
  logic             vld_p [NB];
  logic             ovf_p;

  // Inputs seen by each block and the merged partial sum it produces.
  logic [WIDTH-1:0] op_a     [NB];
  logic [WIDTH-1:0] op_b     [NB];
  logic [WIDTH-1:0] part_sum [NB];
  logic [WIDTH-1:0] new_sum  [NB];
  logic             op_c     [NB];
  logic             op_v     [NB];
  logic [BLOCK+1:0] blk      [NB];
  logic             stall;

  assign stall = vld_p[NB-1] & ~bus.out_ready;

  always_comb begin
    // Stage 0 boundary: operands straight from the bus; subtraction is
    // a + ~b + 1, so the carry in is forced high and cy_in is dropped.
    op_a[0]     = bus.a;
    op_b[0]     = bus.sub ? ~bus.b : bus.b;
    op_c[0]     = bus.sub | bus.cy_in;
    part_sum[0] = '0;
    op_v[0]     = bus.in_valid;
    for (int k = 1; k < NB; k++) begin
      op_a[k]     = a_p[k-1];
      op_b[k]     = b_p[k-1];
      op_c[k]     = cy_p[k-1];
      part_sum[k] = sum_p[k-1];
      op_v[k]     = vld_p[k-1];
    end
    for (int k = 0; k < NB; k++) begin
      blk[k]     = cla_block(op_a[k][k*BLOCK +: BLOCK],
                             op_b[k][k*BLOCK +: BLOCK], op_c[k]);
      new_sum[k] = part_sum[k];
      new_sum[k][k*BLOCK +: BLOCK] = blk[k][BLOCK-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NB; k++) begin
        vld_p[k] <= 1'b0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        sum_p[k] <= '0;
        cy_p[k]  <= 1'b0;
      end
      ovf_p <= 1'b0;
    end else if (!stall) begin
      // Stage k+1 boundary: block k resolved. Data only loads behind a
      // valid op so the output holds its last result while idle.
      for (int k = 0; k < NB; k++) begin
        vld_p[k] <= op_v[k];
        if (op_v[k]) begin
          a_p[k]   <= op_a[k];
          b_p[k]   <= op_b[k];
          sum_p[k] <= new_sum[k];
          cy_p[k]  <= blk[k][BLOCK];
        end
      end
      // Last stage boundary: overflow from carry into vs. out of the MSB.
      if (op_v[NB-1]) ovf_p <= blk[NB-1][BLOCK+1] ^ blk[NB-1][BLOCK];
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vld_p[NB-1];
  assign bus.sum       = sum_p[NB-1];
  assign bus.cy_out    = cy_p[NB-1];
  assign bus.ovf       = ovf_p;

endmodule

// File: tb/tb_pipelined_block_adder.sv
// Bench for pipelined_block_adder: a 32/4 instance driven by directed
// vectors and hand sequences, plus 8/4 and 12/3 instances checked against
// a behavioural add model under random traffic and random backpressure.
module tb_pipelined_block_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipelined_block_adder_if #(.WIDTH(32)) bus32 ();
  pipelined_block_adder_if #(.WIDTH(8))  bus8  ();
  pipelined_block_adder_if #(.WIDTH(12)) bus12 ();

  pipelined_block_adder #(.WIDTH(32), .BLOCK(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  pipelined_block_adder #(.WIDTH(8),  .BLOCK(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  pipelined_block_adder #(.WIDTH(12), .BLOCK(3)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sb;
    logic [31:0] sum;
    logic        cy;
    logic        ov;
  } vec_t;

  vec_t        vecs [10];
  logic [33:0] q8  [$];
  logic [33:0] q12 [$];
  logic [33:0] e8, e12;
  int          lat, nv, nacc, nres, lat8, lat12;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sb);
    bus32.a     = a;
    bus32.b     = b;
    bus32.cy_in = cin;
    bus32.sub   = sb;
  endtask

  // Reference: {carry out, signed overflow, sum} of a w-bit add/sub.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sb);
    logic [63:0] mask, eb, tot;
    logic [31:0] s;
    logic        cy, ov;
    mask = (64'd1 << w) - 64'd1;
    eb   = sb ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
    tot  = ({32'd0, a} & mask) + eb + {63'd0, (sb ? 1'b1 : cin)};
    s    = tot[31:0] & mask[31:0];
    cy   = tot[w];
    ov   = (a[w-1] == eb[w-1]) && (s[w-1] != a[w-1]);
    return {cy, ov, s};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit, want bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h12345678, 32'h0FEDCBA8, 1'b1, 1'b0, 32'h22222221, 1'b0, 1'b0};
    vecs[4] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[7] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[8] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[9] = '{32'h0000000F, 32'h00000001, 1'b0, 1'b0, 32'h00000010, 1'b0, 1'b0};

    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; op32(32'd0, 32'd0, 1'b0, 1'b0);
    bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b1; bus8.a  = '0; bus8.b  = '0; bus8.cy_in  = 1'b0; bus8.sub  = 1'b0;
    bus12.in_valid = 1'b0; bus12.out_ready = 1'b1; bus12.a = '0; bus12.b = '0; bus12.cy_in = 1'b0; bus12.sub = 1'b0;

    // Reset asserted mid-cycle must clear outputs without an edge.
    #3 rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus32.out_valid, 1'b0);
    check("rst_in_ready",  bus32.in_ready,  1'b1);
    check("rst_sum",       bus32.sum,       32'd0);
    check("rst_cy_out",    bus32.cy_out,    1'b0);
    check("rst_ovf",       bus32.ovf,       1'b0);
    check("rst_out_valid8", bus8.out_valid, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, one op at a time.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      op32(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb);
      bus32.in_valid = 1'b1;
      lat = 0;
      do begin
        @(negedge clk);
        bus32.in_valid = 1'b0;
        lat++;
      end while (!bus32.out_valid && lat < 20);
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_sum", i),     bus32.sum,    vecs[i].sum);
      check($sformatf("vec%0d_cy_out", i),  bus32.cy_out, vecs[i].cy);
      check($sformatf("vec%0d_ovf", i),     bus32.ovf,    vecs[i].ov);
      @(negedge clk);
      check($sformatf("vec%0d_one_cycle", i), bus32.out_valid, 1'b0);
    end

    // Three ops on consecutive cycles.
    @(negedge clk); op32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0); bus32.in_valid = 1'b1;
    @(negedge clk); op32(32'h00000005, 32'h00000007, 1'b0, 1'b1);
    @(negedge clk); op32(32'h12345678, 32'h0FEDCBA8, 1'b1, 1'b0);
    @(negedge clk); bus32.in_valid = 1'b0;
    lat = 3;
    while (!bus32.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_latency", lat, 8);
    check("b2b_res0", {bus32.out_valid, bus32.sum, bus32.cy_out, bus32.ovf}, {1'b1, 32'h80000000, 1'b0, 1'b1});
    @(negedge clk);
    check("b2b_res1", {bus32.out_valid, bus32.sum, bus32.cy_out, bus32.ovf}, {1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});
    @(negedge clk);
    check("b2b_res2", {bus32.out_valid, bus32.sum, bus32.cy_out, bus32.ovf}, {1'b1, 32'h22222221, 1'b0, 1'b0});
    @(negedge clk);
    check("b2b_end", bus32.out_valid, 1'b0);

    // Fill the pipe, then stall the output for three cycles.
    nacc = 0;
    nres = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      bus32.out_ready = !(c >= 8 && c <= 10);
      bus32.in_valid  = (nacc < 9);
      op32(32'h10000000 + nacc, nacc, 1'b0, 1'b0);
      #1;
      if (c >= 8 && c <= 10) begin
        check($sformatf("bp_in_ready_c%0d", c), bus32.in_ready, 1'b0);
        check($sformatf("bp_sum_held_c%0d", c), bus32.sum, 32'h10000000);
      end
      if (c == 11) check("bp_in_ready_back", bus32.in_ready, 1'b1);
      if (bus32.out_valid && bus32.out_ready) begin
        if (nres < 9) check($sformatf("bp_result%0d", nres), bus32.sum, 32'h10000000 + 2 * nres);
        else          check("bp_extra_result", bus32.out_valid, 1'b0);
        nres++;
      end
      if (bus32.in_valid && bus32.in_ready) nacc++;
    end
    check("bp_result_count", nres, 9);
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;

    // Reset with five ops in flight, then a single fresh op.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op32(i + 1, 32'h00000100, 1'b0, 1'b0);
      bus32.in_valid = 1'b1;
    end
    @(negedge clk);
    bus32.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus32.out_valid, 1'b0);
    check("midrst_in_ready",  bus32.in_ready,  1'b1);
    check("midrst_sum",       bus32.sum,       32'd0);
    check("midrst_cy_ovf",    {bus32.cy_out, bus32.ovf}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    op32(32'h00ABCDEF, 32'h00111111, 1'b0, 1'b0);
    bus32.in_valid = 1'b1;
    nv  = 0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus32.in_valid = 1'b0;
      if (bus32.out_valid) begin
        nv++;
        if (nv == 1) begin
          lat = c;
          check("midrst_new_sum", bus32.sum, 32'h00BCDF00);
        end
      end
    end
    check("midrst_latency", lat, 8);
    check("midrst_result_count", nv, 1);

    // Small instances: latency of the first op.
    @(negedge clk);
    bus8.a  = 8'hF0;   bus8.b  = 8'h10;   bus8.in_valid  = 1'b1;
    bus12.a = 12'h7FF; bus12.b = 12'h001; bus12.in_valid = 1'b1;
    lat8  = 0;
    lat12 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus8.in_valid  = 1'b0;
      bus12.in_valid = 1'b0;
      if (bus8.out_valid && lat8 == 0) begin
        lat8 = c;
        check("w8_first_result", {bus8.cy_out, bus8.ovf, bus8.sum}, {1'b1, 1'b0, 8'h00});
      end
      if (bus12.out_valid && lat12 == 0) begin
        lat12 = c;
        check("w12_first_result", {bus12.cy_out, bus12.ovf, bus12.sum}, {1'b0, 1'b1, 12'h800});
      end
    end
    check("w8_latency", lat8, 2);
    check("w12_latency", lat12, 4);

    // Random traffic with random backpressure, then drain.
    for (int c = 0; c < 10040; c++) begin
      @(negedge clk);
      bus8.in_valid   = (c < 10000) && ($urandom_range(0, 3) != 0);
      bus8.a          = 8'($urandom);
      bus8.b          = 8'($urandom);
      bus8.cy_in      = 1'($urandom);
      bus8.sub        = 1'($urandom);
      bus8.out_ready  = (c >= 10000) || ($urandom_range(0, 3) != 0);
      bus12.in_valid  = (c < 10000) && ($urandom_range(0, 3) != 0);
      bus12.a         = 12'($urandom);
      bus12.b         = 12'($urandom);
      bus12.cy_in     = 1'($urandom);
      bus12.sub       = 1'($urandom);
      bus12.out_ready = (c >= 10000) || ($urandom_range(0, 3) != 0);
      #1;
      if (bus8.out_valid && bus8.out_ready) begin
        if (q8.size() == 0) check("rand8_unexpected", bus8.out_valid, 1'b0);
        else begin
          e8 = q8.pop_front();
          check("rand8_result", {bus8.cy_out, bus8.ovf, 24'd0, bus8.sum}, e8);
        end
      end
      if (bus8.in_valid && bus8.in_ready)
        q8.push_back(model(8, {24'd0, bus8.a}, {24'd0, bus8.b}, bus8.cy_in, bus8.sub));
      if (bus12.out_valid && bus12.out_ready) begin
        if (q12.size() == 0) check("rand12_unexpected", bus12.out_valid, 1'b0);
        else begin
          e12 = q12.pop_front();
          check("rand12_result", {bus12.cy_out, bus12.ovf, 20'd0, bus12.sum}, e12);
        end
      end
      if (bus12.in_valid && bus12.in_ready)
        q12.push_back(model(12, {20'd0, bus12.a}, {20'd0, bus12.b}, bus12.cy_in, bus12.sub));
    end
    check("rand8_leftover",  q8.size(),  0);
    check("rand12_leftover", q12.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
